// File: rtl/fpaddsub_arbiter.sv
// rtl/fpaddsub_arbiter.sv - two-requester round-robin issue sequencer for a shared pipelined FP add/sub unit
module fpaddsub_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  input  logic        req_op_0,
  input  logic        req_op_1,
  output logic [31:0] u_a,
  output logic [31:0] u_b,
  output logic        u_opmode,
  output logic [3:0]  u_alumode,
  output logic        u_valid,
  input  logic [31:0] u_z,
  output logic [31:0] res_z,
  output logic        res_valid_0,
  output logic        res_valid_1,
  output logic [4:0]  inflight
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  // priority pointer: requester that wins the next tie
  logic pri;
  // owner of the operation currently on the unit inputs
  logic u_owner;
  // tag pipeline tracking issued operations through the unit latency
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_owner;

  logic hs_0;
  logic hs_1;
  logic hs;
  logic tag_exit;
  logic res_any;

  // grant selection; reset and enable gate every grant
  always_comb begin
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    if (rst_n && en) begin
      if (req_valid_0 && (!req_valid_1 || !pri)) begin
        req_ready_0 = 1'b1;
      end else if (req_valid_1) begin
        req_ready_1 = 1'b1;
      end
    end
  end

  assign hs_0     = req_valid_0 & req_ready_0;
  assign hs_1     = req_valid_1 & req_ready_1;
  assign hs       = hs_0 | hs_1;
  assign tag_exit = tag_valid[LAT-1];
  assign res_any  = res_valid_0 | res_valid_1;

  // round-robin pointer flips to the other requester after each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri <= 1'b0;
    end else if (hs_0) begin
      pri <= 1'b1;
    end else if (hs_1) begin
      pri <= 1'b0;
    end
  end

  // issue register: load operands from the granted requester, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_a       <= 32'd0;
      u_b       <= 32'd0;
      u_opmode  <= 1'b0;
      u_alumode <= ALU_ADD;
      u_valid   <= 1'b0;
      u_owner   <= 1'b0;
    end else begin
      u_valid <= hs;
      if (hs_0) begin
        u_a       <= req_a_0;
        u_b       <= req_b_0;
        u_opmode  <= req_op_0;
        u_alumode <= req_op_0 ? ALU_SUB : ALU_ADD;
        u_owner   <= 1'b0;
      end else if (hs_1) begin
        u_a       <= req_a_1;
        u_b       <= req_b_1;
        u_opmode  <= req_op_1;
        u_alumode <= req_op_1 ? ALU_SUB : ALU_ADD;
        u_owner   <= 1'b1;
      end
    end
  end

  // tag shift register aligned so its last stage coincides with a valid U_Z
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= u_valid;
      tag_owner[0] <= u_owner;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  // result capture: U_Z is only taken when a live tag leaves the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_z       <= 32'd0;
      res_valid_0 <= 1'b0;
      res_valid_1 <= 1'b0;
    end else begin
      res_valid_0 <= tag_exit & ~tag_owner[LAT-1];
      res_valid_1 <= tag_exit &  tag_owner[LAT-1];
      if (tag_exit) begin
        res_z <= u_z;
      end
    end
  end

  // outstanding count: up on handshake, down on delivered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 5'd0;
    end else begin
      case ({hs, res_any})
        2'b10:   inflight <= inflight + 5'd1;
        2'b01:   inflight <= inflight - 5'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// tb/tb_fpaddsub_arbiter.sv - scoreboard bench for fpaddsub_arbiter
module tb_fpaddsub_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        req_op_0, req_op_1;
  logic [31:0] u_a, u_b;
  logic        u_opmode;
  logic [3:0]  u_alumode;
  logic        u_valid;
  logic [31:0] u_z;
  logic [31:0] res_z;
  logic        res_valid_0, res_valid_1;
  logic [4:0]  inflight;

  fpaddsub_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .u_a(u_a), .u_b(u_b), .u_opmode(u_opmode), .u_alumode(u_alumode),
    .u_valid(u_valid), .u_z(u_z),
    .res_z(res_z), .res_valid_0(res_valid_0), .res_valid_1(res_valid_1),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  // directed operand vectors with hand-computed unit results (model returns A^B)
  logic [31:0] va [8] = '{32'h3F800000, 32'h40400000, 32'h41200000, 32'hC0000000,
                          32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA};
  logic [31:0] vb [8] = '{32'h40000000, 32'h3F800000, 32'h00000001, 32'h40000000,
                          32'h0000FFFF, 32'h0F0F0F0F, 32'hBF800000, 32'h55555555};
  logic [31:0] vz [8] = '{32'h7F800000, 32'h7FC00000, 32'h41200001, 32'h80000000,
                          32'h1234A987, 32'hF0F0F0F0, 32'hBF800000, 32'hFFFFFFFF};
  logic        vop [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // unit model: free-running LAT-deep pipeline of A^B, never reset
  logic [31:0] upipe [LAT];
  always @(posedge clk) begin
    upipe[0] <= u_a ^ u_b;
    for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign u_z = upipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        owner;
    logic [31:0] z;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops an expectation whenever a result strobe is seen
  always @(negedge clk) begin
    exp_t e;
    if (res_valid_0 || res_valid_1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=rv0:%b rv1:%b z=%h expected=none (cycle %0d)",
                 res_valid_0, res_valid_1, res_z, cyc);
      end else begin
        e = q.pop_front();
        chk("res_valid_0", 32'(res_valid_0), 32'(!e.owner));
        chk("res_valid_1", 32'(res_valid_1), 32'(e.owner));
        chk("res_z", res_z, e.z);
        chk("res_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (q.size() != 0 && cyc >= q[0].cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_result actual=none expected=z:%h owner:%0d at cycle %0d",
               q[0].z, q[0].owner, q[0].cyc);
      void'(q.pop_front());
    end
  end

  // present one cycle of stimulus; exp_g is the expected grant (-1 none)
  task automatic drive(input logic v0, input int i0, input logic v1, input int i1,
                       input logic e, input int exp_g);
    exp_t ent;
    int   idx;
    req_valid_0 = v0; req_a_0 = va[i0]; req_b_0 = vb[i0]; req_op_0 = vop[i0];
    req_valid_1 = v1; req_a_1 = va[i1]; req_b_1 = vb[i1]; req_op_1 = vop[i1];
    en = e;
    #1;
    chk("req_ready_0", 32'(req_ready_0), 32'(exp_g == 0));
    chk("req_ready_1", 32'(req_ready_1), 32'(exp_g == 1));
    idx = (exp_g == 1) ? i1 : i0;
    if (exp_g >= 0) begin
      ent.owner = (exp_g == 1);
      ent.z     = vz[idx];
      ent.cyc   = cyc + LAT + 2;
      q.push_back(ent);
    end
    @(negedge clk);
    chk("u_valid", 32'(u_valid), 32'(exp_g >= 0));
    if (exp_g >= 0) begin
      chk("u_a", u_a, va[idx]);
      chk("u_b", u_b, vb[idx]);
      chk("u_opmode", 32'(u_opmode), 32'(vop[idx]));
      chk("u_alumode", 32'(u_alumode), vop[idx] ? 32'h3 : 32'h0);
    end
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  task automatic idle(input logic e, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 0, e, -1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready_0", 32'(req_ready_0), 32'h0);
    chk("rst_req_ready_1", 32'(req_ready_1), 32'h0);
    chk("rst_u_a", u_a, 32'h0);
    chk("rst_u_b", u_b, 32'h0);
    chk("rst_u_opmode", 32'(u_opmode), 32'h0);
    chk("rst_u_alumode", 32'(u_alumode), 32'h0);
    chk("rst_u_valid", 32'(u_valid), 32'h0);
    chk("rst_res_z", res_z, 32'h0);
    chk("rst_res_valid_0", 32'(res_valid_0), 32'h0);
    chk("rst_res_valid_1", 32'(res_valid_1), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
  endtask

  // pulse reset for one cycle starting at a negedge; pending expectations are discarded
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    q.delete();
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_a_0 = 32'h0; req_b_0 = 32'h0; req_a_1 = 32'h0; req_b_1 = 32'h0;
    req_op_0 = 1'b0; req_op_1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // single add from requester 0
    drive(1'b1, 0, 1'b0, 0, 1'b1, 0);
    chk("single_inflight_1", 32'(inflight), 32'd1);
    idle(1'b1, 7);
    chk("single_inflight_0", 32'(inflight), 32'd0);
    chk("single_res_z_hold", res_z, 32'h7F800000);

    // subtract from requester 1
    drive(1'b0, 0, 1'b1, 1, 1'b1, 1);
    idle(1'b1, 7);
    chk("sub_res_z_hold", res_z, 32'h7FC00000);

    // contention from reset: both valid for 8 cycles, grants alternate 0,1,...
    reset_pulse();
    peak = 0;
    for (int j = 0; j < 8; j++) drive(1'b1, 2 * ((j + 1) / 2), 1'b1, 2 * (j / 2) + 1, 1'b1, j % 2);
    idle(1'b1, 7);
    chk("contention_peak", 32'(peak), 32'd6);
    chk("contention_inflight_0", 32'(inflight), 32'd0);

    // lone requester 1 for 5 cycles, then a tie goes to requester 0
    for (int j = 0; j < 5; j++) drive(1'b0, 0, 1'b1, j, 1'b1, 1);
    drive(1'b1, 5, 1'b1, 6, 1'b1, 0);
    idle(1'b1, 7);

    // enable drops one cycle after three issues; readies close immediately
    for (int j = 0; j < 3; j++) drive(1'b1, j, 1'b0, 0, 1'b1, 0);
    for (int j = 0; j < 7; j++) drive(1'b1, 3, 1'b1, 4, 1'b0, -1);
    chk("en_inflight_0", 32'(inflight), 32'd0);
    chk("en_queue_drained", 32'(q.size()), 32'd0);

    // reset two cycles after two issues; no stale results may appear
    drive(1'b1, 7, 1'b1, 6, 1'b1, 1);
    drive(1'b1, 7, 1'b0, 0, 1'b1, 0);
    idle(1'b1, 2);
    reset_pulse();
    idle(1'b1, 10);
    chk("rstmid_inflight", 32'(inflight), 32'd0);
    chk("rstmid_res_z", res_z, 32'h0);

    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpaddsub_arbiter.md
# fpaddsub_arbiter

Round-robin arbiter and issue sequencer that shares one fixed-latency pipelined FP add/sub unit (the DSP48E1-based FPAddSub datapath) between two requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle. It drives the unit's operands, OpMode and DSP ALUMODE/clock-enable, and tracks each in-flight operation's owner in a tag pipeline. Each returned result is routed back to the requester that issued it.

## Interface
- `LAT`, default 4: cycles from a `U_VALID` cycle to the cycle `U_Z` is valid; legal range 1..16.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `EN` in 1: grant enable. Low blocks new grants; in-flight operations still complete.
- `REQ_VALID_0`, `REQ_VALID_1` in 1: requester has an operation.
- `REQ_READY_0`, `REQ_READY_1` out 1: grant; the handshake completes when valid and ready are both high at a rising edge.
- `REQ_A_0`, `REQ_B_0`, `REQ_A_1`, `REQ_B_1` in 32: IEEE-754 single operands.
- `REQ_OP_0`, `REQ_OP_1` in 1: 0 = add, 1 = subtract.
- `U_A`, `U_B` out 32: registered operands to the unit.
- `U_OPMODE` out 1: registered OpMode to the unit.
- `U_ALUMODE` out 4: 4'b0000 for add, 4'b0011 for subtract.
- `U_VALID` out 1: issue strobe and unit clock enable for the operation.
- `U_Z` in 32: unit result, valid exactly `LAT` cycles after the `U_VALID` cycle.
- `RES_Z` out 32: registered result bus shared by both requesters.
- `RES_VALID_0`, `RES_VALID_1` out 1: one-cycle strobe marking `RES_Z` as belonging to requester i. There is no back-pressure.
- `INFLIGHT` out 5: number of operations handshaken but not yet returned.

## Operation
- **Arbitration (combinational).**
  - If `EN`=0, both readies are 0.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester selected by the priority pointer `PRI` is granted.
  - Ready may depend on valid. At most one ready is high in any cycle.
- **Priority update.** On a handshake by requester i, `PRI` becomes 1-i. `PRI` does not change without a handshake.
- **Issue.** On the handshake edge, `U_A`, `U_B`, `U_OPMODE` and `U_ALUMODE` are loaded from the granted requester and `U_VALID` is set. With no handshake, `U_VALID` clears and the other `U_*` outputs hold their values.
- **Tag pipeline.** A shift register of depth `LAT` carries {valid, owner}. The entry is pushed with `U_VALID`. When the entry exits, `RES_Z` captures `U_Z` and `RES_VALID_owner` pulses for one cycle.
  - `RES_Z` holds its value when no entry exits.
  - `U_Z` is ignored when no tag is valid.
- **INFLIGHT accounting.**
  - +1 on a handshake; −1 on any `RES_VALID` pulse; unchanged when both occur in the same cycle.
  - Maximum value is `LAT`+2, which fits in 5 bits for `LAT`≤16.
- **Ordering.** Results return in issue order; one result per cycle at most.
- **EN falling mid-flight.** No new grants are made; every tag already issued still produces its `RES_VALID`.

## Timing
- **Reset values:**
  - `REQ_READY_*`=0 while `RST_N`=0, because grants are gated by reset.
  - `U_A`=`U_B`=0, `U_OPMODE`=0, `U_ALUMODE`=0, `U_VALID`=0.
  - `RES_Z`=0, `RES_VALID_*`=0, `INFLIGHT`=0.
  - `PRI`=0 (requester 0 wins the first tie); tag pipeline cleared.
- **Latency:** for a handshake at edge k:
  - `U_VALID` is high in cycle k+1.
  - `U_Z` is sampled at the end of cycle k+1+`LAT`.
  - `RES_VALID` is high in cycle k+2+`LAT`.
  - Total is `LAT`+2 cycles.
- **Throughput:** one issue per cycle sustained, including alternating requesters under contention.
- **Reset mid-operation:** all in-flight tags are discarded. No `RES_VALID` fires for operations issued before reset, even if the unit later presents `U_Z`.
- **Reset release:** grants may occur on the first edge after `RST_N` rises.

## Test plan
- **Single add:** `LAT`=4; the bench unit model returns `U_A`^`U_B` delayed by `LAT`. Drive `REQ_VALID_0`=1, A=0x3F800000, B=0x40000000, OP=0, for one handshake at edge k.
  - `U_VALID` high at k+1 with `U_ALUMODE`=0000.
  - `RES_VALID_0` high only in cycle k+6 with `RES_Z`=0x7F800000.
  - `INFLIGHT` goes 1 then back to 0.
- **Subtract from requester 1:** OP=1, A=0x40400000, B=0x3F800000.
  - `U_OPMODE`=1, `U_ALUMODE`=0011.
  - `RES_VALID_1` pulse with `RES_Z`=0x7FC00000; `RES_VALID_0` stays 0.
- **Contention:** both valid continuously for 8 cycles from reset.
  - Grants alternate 0,1,0,1,...
  - 8 results return in issue order with matching owner strobes.
  - `INFLIGHT` peaks at 6.
- **Lone requester:** only `REQ_VALID_1` held high for 5 cycles.
  - 5 back-to-back grants to requester 1.
  - Next tie afterwards goes to requester 0.
- **EN gating:** `EN` drops 1 cycle after 3 issues.
  - Readies go to 0 immediately.
  - All 3 results still arrive.
  - `INFLIGHT` ends at 0.
- **Reset mid-flight:** pulse `RST_N` low for 1 cycle, 2 cycles after 2 issues.
  - All outputs return to their reset values.
  - No `RES_VALID` pulses are seen afterwards, despite the unit model presenting `U_Z`.
